// File: rtl/mux_test_sequencer.sv
// Sweeps all 64 select/data combinations into two mux4 implementations and counts mismatches.
// Optional first-failure capture is compiled in with `define MUX_TEST_FIRST_FAIL_EN.
module mux_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gf_out,
  input  logic       bfg_out,
  output logic       i0,
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] gf_err,
  output logic [6:0] bfg_err,
`ifdef MUX_TEST_FIRST_FAIL_EN
  output logic [6:0] diff_err,
  output logic       fail_valid,
  output logic [5:0] fail_vec
`else
  output logic [6:0] diff_err
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] vec_q, vec_d;
  logic [5:0] stim_q, stim_d;
  logic [3:0] settle_q, settle_d;
  logic [6:0] gf_err_q, gf_err_d;
  logic [6:0] bfg_err_q, bfg_err_d;
  logic [6:0] diff_err_q, diff_err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       expected;
  logic       gf_miss, bfg_miss, diff_miss;

  // Reference value is derived from the registered stimulus, i.e. what the muxes actually see.
  always_comb begin
    expected = 1'b0;
    case (stim_q[5:4])
      2'd0: expected = stim_q[0];
      2'd1: expected = stim_q[1];
      2'd2: expected = stim_q[2];
      2'd3: expected = stim_q[3];
      default: expected = 1'b0;
    endcase
  end

  assign gf_miss   = gf_out ^ expected;
  assign bfg_miss  = bfg_out ^ expected;
  assign diff_miss = gf_out ^ bfg_out;

`ifdef MUX_TEST_FIRST_FAIL_EN
  logic       fail_valid_q, fail_valid_d;
  logic [5:0] fail_vec_q, fail_vec_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    vec_d      = vec_q;
    stim_d     = stim_q;
    settle_d   = settle_q;
    gf_err_d   = gf_err_q;
    bfg_err_d  = bfg_err_q;
    diff_err_d = diff_err_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
`ifdef MUX_TEST_FIRST_FAIL_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          vec_d      = '0;
          gf_err_d   = '0;
          bfg_err_d  = '0;
          diff_err_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
`ifdef MUX_TEST_FIRST_FAIL_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
`endif
        end
      end
      ST_DRIVE: begin
        stim_d   = vec_q;
        settle_d = SETTLE_LOAD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 4'd0) state_d = ST_SAMPLE;
        else                  settle_d = settle_q - 4'd1;
      end
      ST_SAMPLE: begin
        gf_err_d   = gf_err_q + {6'd0, gf_miss};
        bfg_err_d  = bfg_err_q + {6'd0, bfg_miss};
        diff_err_d = diff_err_q + {6'd0, diff_miss};
`ifdef MUX_TEST_FIRST_FAIL_EN
        if (!fail_valid_q && (gf_miss || bfg_miss || diff_miss)) begin
          fail_valid_d = 1'b1;
          fail_vec_d   = vec_q;
        end
`endif
        if (vec_q == 6'd63) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (gf_err_d == 7'd0) && (bfg_err_d == 7'd0) && (diff_err_d == 7'd0);
        end else begin
          vec_d   = vec_q + 6'd1;
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      stim_q     <= '0;
      settle_q   <= '0;
      gf_err_q   <= '0;
      bfg_err_q  <= '0;
      diff_err_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      vec_q      <= vec_d;
      stim_q     <= stim_d;
      settle_q   <= settle_d;
      gf_err_q   <= gf_err_d;
      bfg_err_q  <= bfg_err_d;
      diff_err_q <= diff_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

`ifdef MUX_TEST_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
`endif

  assign {s1, s0, i3, i2, i1, i0} = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign gf_err   = gf_err_q;
  assign bfg_err  = bfg_err_q;
  assign diff_err = diff_err_q;

endmodule

// File: tb/tb_mux_test_sequencer.sv
// Directed bench for mux_test_sequencer: fault-injected mux models, restart/reset handling and
// sweep length for SETTLE_CYCLES = 2, 1 and 15.
module tb_mux_test_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  bit f_bfg0 = 1'b0;   // generated mux stuck at 0
  bit f_gf3  = 1'b0;   // standard-cell mux inverted when {s1,s0}=3
  bit f_gfall = 1'b0;  // standard-cell mux always inverted

  int n_cmp = 0;
  int n_fail = 0;

  logic [5:0] m_stim, a_stim, b_stim;
  logic       m_gf, m_bfg, a_mux, b_mux;
  logic       m_busy, m_done, m_pass, a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [6:0] m_gf_err, m_bfg_err, m_diff_err;
  logic [6:0] a_gf_err, a_bfg_err, a_diff_err, b_gf_err, b_bfg_err, b_diff_err;
`ifdef MUX_TEST_FIRST_FAIL_EN
  logic       m_fv, a_fv, b_fv;
  logic [5:0] m_fvec, a_fvec, b_fvec;
`endif

  function automatic logic ideal_mux(input logic [5:0] v);
    case ({v[5], v[4]})
      2'b00:   return v[0];
      2'b01:   return v[1];
      2'b10:   return v[2];
      default: return v[3];
    endcase
  endfunction

  assign m_gf  = ideal_mux(m_stim) ^ (f_gfall | (f_gf3 & (m_stim[5:4] == 2'b11)));
  assign m_bfg = f_bfg0 ? 1'b0 : ideal_mux(m_stim);
  assign a_mux = ideal_mux(a_stim);
  assign b_mux = ideal_mux(b_stim);

  mux_test_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .gf_out(m_gf), .bfg_out(m_bfg),
    .i0(m_stim[0]), .i1(m_stim[1]), .i2(m_stim[2]), .i3(m_stim[3]), .s0(m_stim[4]), .s1(m_stim[5]),
    .busy(m_busy), .done(m_done), .pass(m_pass),
    .gf_err(m_gf_err), .bfg_err(m_bfg_err),
`ifdef MUX_TEST_FIRST_FAIL_EN
    .fail_valid(m_fv), .fail_vec(m_fvec),
`endif
    .diff_err(m_diff_err)
  );

  mux_test_sequencer #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start), .gf_out(a_mux), .bfg_out(a_mux),
    .i0(a_stim[0]), .i1(a_stim[1]), .i2(a_stim[2]), .i3(a_stim[3]), .s0(a_stim[4]), .s1(a_stim[5]),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .gf_err(a_gf_err), .bfg_err(a_bfg_err),
`ifdef MUX_TEST_FIRST_FAIL_EN
    .fail_valid(a_fv), .fail_vec(a_fvec),
`endif
    .diff_err(a_diff_err)
  );

  mux_test_sequencer #(.SETTLE_CYCLES(15)) dut_s15 (
    .clk(clk), .rst(rst), .start(start), .gf_out(b_mux), .bfg_out(b_mux),
    .i0(b_stim[0]), .i1(b_stim[1]), .i2(b_stim[2]), .i3(b_stim[3]), .s0(b_stim[4]), .s1(b_stim[5]),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .gf_err(b_gf_err), .bfg_err(b_bfg_err),
`ifdef MUX_TEST_FIRST_FAIL_EN
    .fail_valid(b_fv), .fail_vec(b_fvec),
`endif
    .diff_err(b_diff_err)
  );

  int cyc_m, cyc_a, cyc_b, distinct;
  bit seen [64];

  // Pulse start, then count edges (start edge = 0) until each done rises; 0 means it never did.
  task automatic do_sweep(input int restart_at, input bit wait_all, input int limit);
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;
    distinct = 0;
    cyc_m = 0; cyc_a = 0; cyc_b = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_cmp++; if (m_busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b want 1", m_busy); end
    n_cmp++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL start_done_clear got %b want 0", m_done); end
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (!seen[m_stim]) begin seen[m_stim] = 1'b1; distinct++; end
      if (m_done && cyc_m == 0) cyc_m = c;
      if (a_done && cyc_a == 0) cyc_a = c;
      if (b_done && cyc_b == 0) cyc_b = c;
      if (cyc_m != 0 && (!wait_all || (cyc_a != 0 && cyc_b != 0))) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({m_busy, m_done, m_pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {m_busy, m_done, m_pass}); end
    n_cmp++; if (m_stim !== 6'd0) begin n_fail++; $display("FAIL reset_stim got %0d want 0", m_stim); end
    n_cmp++; if ({m_gf_err, m_bfg_err, m_diff_err} !== 21'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", m_gf_err, m_bfg_err, m_diff_err); end
`ifdef MUX_TEST_FIRST_FAIL_EN
    n_cmp++; if ({m_fv, m_fvec} !== 7'd0) begin n_fail++; $display("FAIL reset_fail_capture got %b/%0d want 0/0", m_fv, m_fvec); end
`endif
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  // One directed fault pattern per call; expectations are hand-computed by the caller.
  task automatic test_fault(input string name, input bit bfg0, input bit gf3, input bit gfall,
                            input int e_gf, input int e_bfg, input int e_diff, input bit e_pass,
                            input bit e_fv, input int e_fvec);
    f_bfg0 = bfg0; f_gf3 = gf3; f_gfall = gfall;
    do_sweep(0, 1'b0, 400);
    n_cmp++; if (cyc_m != 256) begin n_fail++; $display("FAIL %s_length got %0d want 256", name, cyc_m); end
    n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy got %b want 0", name, m_busy); end
    n_cmp++; if (m_gf_err !== 7'(e_gf)) begin n_fail++; $display("FAIL %s_gf_err got %0d want %0d", name, m_gf_err, e_gf); end
    n_cmp++; if (m_bfg_err !== 7'(e_bfg)) begin n_fail++; $display("FAIL %s_bfg_err got %0d want %0d", name, m_bfg_err, e_bfg); end
    n_cmp++; if (m_diff_err !== 7'(e_diff)) begin n_fail++; $display("FAIL %s_diff_err got %0d want %0d", name, m_diff_err, e_diff); end
    n_cmp++; if (m_pass !== e_pass) begin n_fail++; $display("FAIL %s_pass got %b want %b", name, m_pass, e_pass); end
`ifdef MUX_TEST_FIRST_FAIL_EN
    n_cmp++; if (m_fv !== e_fv) begin n_fail++; $display("FAIL %s_fail_valid got %b want %b", name, m_fv, e_fv); end
    n_cmp++; if (e_fv && m_fvec !== 6'(e_fvec)) begin n_fail++; $display("FAIL %s_fail_vec got %0d want %0d", name, m_fvec, e_fvec); end
`endif
    f_bfg0 = 1'b0; f_gf3 = 1'b0; f_gfall = 1'b0;
  endtask

  task automatic test_ideal_hold();
    test_fault("ideal", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
    n_cmp++; if (distinct != 64) begin n_fail++; $display("FAIL ideal_distinct_vectors got %0d want 64", distinct); end
    repeat (5) @(posedge clk); #1;
    n_cmp++; if (m_stim !== 6'd63) begin n_fail++; $display("FAIL done_hold_stim got %0d want 63", m_stim); end
    n_cmp++; if (m_done !== 1'b1) begin n_fail++; $display("FAIL done_sticky got %b want 1", m_done); end
  endtask

  task automatic test_restart_ignored();
    do_sweep(100, 1'b0, 400);
    n_cmp++; if (cyc_m != 256) begin n_fail++; $display("FAIL restart_length got %0d want 256", cyc_m); end
    n_cmp++; if (m_pass !== 1'b1) begin n_fail++; $display("FAIL restart_pass got %b want 1", m_pass); end
  endtask

  task automatic test_reset_mid_sweep();
    f_bfg0 = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    // vectors 0..11 sampled by edge 48; bfg mismatches on the odd ones
    n_cmp++; if (m_bfg_err !== 7'd6) begin n_fail++; $display("FAIL midsweep_bfg_err got %0d want 6", m_bfg_err); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({m_busy, m_done, m_pass} !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags got %b want 000", {m_busy, m_done, m_pass}); end
    n_cmp++; if (m_stim !== 6'd0) begin n_fail++; $display("FAIL async_reset_stim got %0d want 0", m_stim); end
    n_cmp++; if ({m_gf_err, m_bfg_err, m_diff_err} !== 21'd0) begin n_fail++; $display("FAIL async_reset_counts got %0d/%0d/%0d want 0/0/0", m_gf_err, m_bfg_err, m_diff_err); end
    f_bfg0 = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    n_cmp++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got %b want 0", m_busy); end
    test_fault("after_reset", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_settle_lengths();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    do_sweep(0, 1'b1, 1200);
    n_cmp++; if (cyc_m != 256) begin n_fail++; $display("FAIL settle2_length got %0d want 256", cyc_m); end
    n_cmp++; if (cyc_a != 192) begin n_fail++; $display("FAIL settle1_length got %0d want 192", cyc_a); end
    n_cmp++; if (cyc_b != 1088) begin n_fail++; $display("FAIL settle15_length got %0d want 1088", cyc_b); end
    n_cmp++; if ({a_pass, b_pass} !== 2'b11) begin n_fail++; $display("FAIL settle_pass got %b want 11", {a_pass, b_pass}); end
  endtask

  initial begin
    test_reset();
    test_fault("bfg_stuck0", 1'b1, 1'b0, 1'b0, 0, 32, 32, 1'b0, 1'b1, 1);
    test_ideal_hold();
    test_fault("gf_sel3_inv", 1'b0, 1'b1, 1'b0, 16, 0, 16, 1'b0, 1'b1, 48);
    test_fault("both_faults", 1'b1, 1'b1, 1'b0, 16, 32, 32, 1'b0, 1'b1, 1);
    test_fault("gf_inv_all", 1'b0, 1'b0, 1'b1, 64, 0, 64, 1'b0, 1'b1, 0);
    test_restart_ignored();
    test_reset_mid_sweep();
    test_settle_lengths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_test_sequencer.md
MUX_TEST_SEQUENCER -- requirements
Module: mux_test_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, giving the clock cycles waited after driving a vector before sampling (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a sweep.
REQ-005 The block SHALL have ports i0, i1, i2, i3, s0, s1, each output, 1 bit: registered stimulus to both mux4 instances under test.
REQ-006 The block SHALL have ports gf_out and bfg_out, each input, 1 bit: the standard-cell and generated mux outputs.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: sticky high after a sweep completes.
REQ-009 The block SHALL have port pass, output, 1 bit: valid when done=1; high iff all three error counts are zero.
REQ-010 The block SHALL have ports gf_err, bfg_err and diff_err, each output, 7 bits: mismatch counts for gf_out vs expected, bfg_out vs expected, and gf_out vs bfg_out.

Function
REQ-011 The block SHALL implement the states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-012 A 6-bit vector counter vec SHALL map to the stimulus outputs as {s1,s0,i3,i2,i1,i0} = vec, registered in DRIVE.
REQ-013 IDLE or DONE with start=1 SHALL go to DRIVE, clear vec, all counters, done and pass, and set busy in the same edge.
REQ-014 DRIVE SHALL go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
REQ-015 SETTLE SHALL decrement the settle counter and go to SAMPLE when it reaches 0, so the stimulus is held exactly SETTLE_CYCLES cycles before sampling.
REQ-016 Expected value SHALL be i0/i1/i2/i3 selected by {s1,s0} = 0/1/2/3.
REQ-017 In SAMPLE, each counter SHALL increment by 1 on its mismatch; all three SHALL be updatable in the same cycle.
REQ-018 SAMPLE with vec<63 SHALL increment vec and go to DRIVE; with vec=63 it SHALL go to DONE (no wrap to 0 within a sweep).
REQ-019 On entry to DONE the block SHALL set done=1, busy=0 and pass=(all counts zero, including the final sample).
REQ-020 Counters SHALL be 7 bits (max 64) with no saturation needed; the count range SHALL be 0..64.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 A sweep SHALL take exactly 64*(SETTLE_CYCLES+2) cycles from the start edge to done rising.
REQ-023 The stimulus outputs SHALL hold the last vector (63) in DONE and IDLE.

Reset
REQ-024 rst=1 SHALL force state IDLE immediately, independent of clk.
REQ-025 rst=1 SHALL force all stimulus outputs, busy, done, pass, vec and all counters to 0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no partial result retained; a new start is required.

Configuration
REQ-027 The macro MUX_TEST_FIRST_FAIL_EN SHALL control a first-failure capture feature.
REQ-028 When MUX_TEST_FIRST_FAIL_EN is defined, the block SHALL add outputs fail_valid (1 bit) and fail_vec (6 bits), latching vec on the first SAMPLE with any mismatch.
REQ-029 When MUX_TEST_FIRST_FAIL_EN is defined, fail_valid and fail_vec SHALL clear on start and on reset, and later failures SHALL NOT overwrite them.
REQ-030 When MUX_TEST_FIRST_FAIL_EN is undefined, the ports and logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Ideal mux models, SETTLE_CYCLES=2, one start pulse -> done after 256 cycles, pass=1, all counts 0, 64 distinct vectors driven.
REQ-032 bfg_out stuck at 0 -> bfg_err=32, diff_err=32, gf_err=0, pass=0; with FIRST_FAIL_EN, fail_vec=6'd1.
REQ-033 gf_out inverted on vectors with {s1,s0}=3 only -> gf_err=16, diff_err=16, bfg_err=0.
REQ-034 start pulsed again at cycle 100 mid-sweep -> ignored; done still rises at cycle 256.
REQ-035 rst asserted at cycle 50 between edges -> outputs 0 immediately; a start afterwards gives a full clean sweep with pass=1.
REQ-036 SETTLE_CYCLES=1 and 15 -> sweep lengths 192 and 1088 cycles respectively.
